// File: rtl/vga_pkg.sv
// Shared definitions for the VGA binary-stream capture path.
//   SYNC_POL_DEF        : default active level of HS/VS (0 = active-low)
//   H_SYNC/H_BACK/...   : 640x480@60 timing, used to derive default window start
//   CNT_W               : width of the line/pixel position counters
//   cap_state_t         : capture FSM encoding
//   ceil_div            : words-per-line helper
package vga_pkg;

  localparam logic SYNC_POL_DEF = 1'b0;

  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;

  localparam int CNT_W = 12;

  typedef enum logic {
    WAIT_VS = 1'b0,
    CAPTURE = 1'b1
  } cap_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Input register plus leading-edge detector for one sync line.
//   clk     : pixel clock
//   rst     : asynchronous, active-high reset
//   sync_in : raw sync from the stream
//   lead    : high for one cycle when the registered sync enters the POL level
module vga_sync_edge
  import vga_pkg::*;
#(
  parameter bit POL = SYNC_POL_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic lead
);

  logic sync_q;
  logic sync_prev;

  // Flops come out of reset at the inactive level, so a sync that is already
  // asserted at release is seen as a fresh leading edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= ~POL;
      sync_prev <= ~POL;
    end else begin
      sync_q    <= sync_in;
      sync_prev <= sync_q;
    end
  end

  assign lead = (sync_q == POL) && (sync_prev != POL);

endmodule

// File: rtl/vga_bin_capture.sv
// Captures a ROW x COL window of a 1-bit VGA pixel stream into a frame RAM,
// DW pixels per word. Pixel position is recovered from HS/VS edges only.
//   iCLK, rst            : pixel clock, async active-high reset
//   iEn                  : capture enable, looked at only on a VS leading edge
//   iVGA_HS/iVGA_VS/iData: incoming stream
//   oWr_en/addr/data     : RAM write port, one word per strobe
//   oBusy                : frame capture in progress
//   oFrame_done          : pulses with the final write of a frame
//   oFrame_err           : pulses when a frame is cut short by a VS edge
//
// state   | meaning
// WAIT_VS | idle, waiting for a VS leading edge with iEn=1
// CAPTURE | packing and writing pixels of the current frame
module vga_bin_capture
  import vga_pkg::*;
#(
  parameter int ROW      = 30,
  parameter int COL      = 30,
  parameter int DW       = 8,
  parameter int H_START  = H_SYNC + H_BACK,
  parameter int V_START  = V_SYNC + V_BACK,
  parameter bit SYNC_POL = SYNC_POL_DEF,
  parameter int AW       = 8
) (
  input  logic          iCLK,
  input  logic          rst,
  input  logic          iEn,
  input  logic          iVGA_HS,
  input  logic          iVGA_VS,
  input  logic          iData,
  output logic          oWr_en,
  output logic [AW-1:0] oWr_addr,
  output logic [DW-1:0] oWr_data,
  output logic          oBusy,
  output logic          oFrame_done,
  output logic          oFrame_err
);

  localparam int WPL = ceil_div(COL, DW);
  localparam int BW  = (DW > 1) ? $clog2(DW) : 1;
  localparam int WW  = $clog2(WPL + 1);

  localparam logic [CNT_W-1:0] H_LO  = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_HI  = CNT_W'(H_START + COL);
  localparam logic [CNT_W-1:0] V_LO  = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_HI  = CNT_W'(V_START + ROW);
  localparam logic [CNT_W-1:0] X_END = CNT_W'(COL - 1);
  localparam logic [CNT_W-1:0] Y_END = CNT_W'(ROW - 1);

  cap_state_t state;

  logic             hs_lead;
  logic             vs_lead;
  logic             data_q;
  logic [CNT_W-1:0] hcnt_r, hcnt_cur;
  logic [CNT_W-1:0] vcnt_r, vcnt_cur;
  logic [CNT_W-1:0] x, y;
  logic             pix_valid;
  logic             word_end;
  logic             frame_last;
  logic [BW-1:0]    bit_r, bit_cur;
  logic [WW-1:0]    word_r, word_cur;
  logic [DW-1:0]    pack_r, word_out;

  vga_sync_edge #(.POL(SYNC_POL)) u_hs_edge (
    .clk    (iCLK),
    .rst    (rst),
    .sync_in(iVGA_HS),
    .lead   (hs_lead)
  );

  vga_sync_edge #(.POL(SYNC_POL)) u_vs_edge (
    .clk    (iCLK),
    .rst    (rst),
    .sync_in(iVGA_VS),
    .lead   (vs_lead)
  );

  // *_cur is the position of the pixel currently in data_q; it reads 0 in
  // the same cycle the edge is detected, so hcnt lines up with data_q.
  always_comb begin
    hcnt_cur = hcnt_r;
    if (hs_lead)
      hcnt_cur = '0;
    else if (hcnt_r != '1)
      hcnt_cur = hcnt_r + 1'b1;

    vcnt_cur = vcnt_r;
    if (vs_lead)
      vcnt_cur = '0;
    else if (hs_lead && (vcnt_r != '1))
      vcnt_cur = vcnt_r + 1'b1;
  end

  always_ff @(posedge iCLK or posedge rst) begin
    if (rst) begin
      data_q <= 1'b0;
      hcnt_r <= '0;
      vcnt_r <= '0;
    end else begin
      data_q <= iData;
      hcnt_r <= hcnt_cur;
      vcnt_r <= vcnt_cur;
    end
  end

  assign x = hcnt_cur - H_LO;
  assign y = vcnt_cur - V_LO;

  assign pix_valid = (state == CAPTURE) &&
                     (hcnt_cur >= H_LO) && (hcnt_cur < H_HI) &&
                     (vcnt_cur >= V_LO) && (vcnt_cur < V_HI);

  // Bit/word position inside the line, tracked incrementally so no divider
  // is needed; x==0 restarts it even if the previous line was cut short.
  assign bit_cur  = (x == '0) ? '0 : bit_r;
  assign word_cur = (x == '0) ? '0 : word_r;

  assign word_end   = (int'(bit_cur) == DW - 1) || (x == X_END);
  assign frame_last = pix_valid && word_end && (x == X_END) && (y == Y_END);

  // Bits above the current position are forced to 0: covers the short last
  // word and any stale bits left by a truncated line.
  always_comb begin
    word_out = '0;
    for (int k = 0; k < DW; k++) begin
      if (k < int'(bit_cur))
        word_out[k] = pack_r[k];
      else if (k == int'(bit_cur))
        word_out[k] = data_q;
    end
  end

  always_ff @(posedge iCLK or posedge rst) begin
    if (rst) begin
      state       <= WAIT_VS;
      bit_r       <= '0;
      word_r      <= '0;
      pack_r      <= '0;
      oWr_en      <= 1'b0;
      oWr_addr    <= '0;
      oWr_data    <= '0;
      oFrame_done <= 1'b0;
      oFrame_err  <= 1'b0;
    end else begin
      oWr_en      <= 1'b0;
      oFrame_done <= 1'b0;
      oFrame_err  <= 1'b0;
      case (state)
        WAIT_VS: begin
          if (vs_lead && iEn) begin
            state  <= CAPTURE;
            pack_r <= '0;
          end
        end
        CAPTURE: begin
          if (vs_lead) begin
            // Frame cut short: drop the partial word, optionally restart.
            oFrame_err <= 1'b1;
            pack_r     <= '0;
            if (!iEn)
              state <= WAIT_VS;
          end else if (pix_valid) begin
            pack_r <= word_out;
            if (word_end) begin
              oWr_en   <= 1'b1;
              oWr_addr <= AW'(int'(y) * WPL + int'(word_cur));
              oWr_data <= word_out;
              bit_r    <= '0;
              word_r   <= word_cur + 1'b1;
              if (frame_last) begin
                oFrame_done <= 1'b1;
                state       <= WAIT_VS;
              end
            end else begin
              bit_r  <= bit_cur + 1'b1;
              word_r <= word_cur;
            end
          end
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

  assign oBusy = (state == CAPTURE);

endmodule

// File: tb/tb_vga_bin_capture.sv
module tb_vga_bin_capture;

  localparam int LINE = 48;
  localparam int HSW  = 3;
  localparam int VSW  = 2;
  localparam int NL   = 40;

  localparam int S_ROW = 4,  S_COL = 10, S_H = 4, S_V = 2, S_AW = 4;
  localparam int D_ROW = 30, D_COL = 30, D_H = 8, D_V = 3, D_AW = 8;

  typedef struct {
    int addr;
    int data;
    int done;
    int cyc;
  } exp_t;

  typedef struct {
    int addr;
    int data;
    int done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_s = 1'b0, en_d = 1'b0;
  logic hs = 1'b1, vs = 1'b1, pix = 1'b0;

  logic            s_wr, s_busy, s_done, s_err;
  logic [S_AW-1:0] s_addr;
  logic [7:0]      s_data;
  logic            d_wr, d_busy, d_done, d_err;
  logic [D_AW-1:0] d_addr;
  logic [7:0]      d_data;

  vga_bin_capture #(.ROW(S_ROW), .COL(S_COL), .DW(8), .H_START(S_H), .V_START(S_V),
                    .SYNC_POL(1'b0), .AW(S_AW)) dut_s (
    .iCLK(clk), .rst(rst), .iEn(en_s), .iVGA_HS(hs), .iVGA_VS(vs), .iData(pix),
    .oWr_en(s_wr), .oWr_addr(s_addr), .oWr_data(s_data), .oBusy(s_busy),
    .oFrame_done(s_done), .oFrame_err(s_err));

  vga_bin_capture #(.ROW(D_ROW), .COL(D_COL), .DW(8), .H_START(D_H), .V_START(D_V),
                    .SYNC_POL(1'b0), .AW(D_AW)) dut_d (
    .iCLK(clk), .rst(rst), .iEn(en_d), .iVGA_HS(hs), .iVGA_VS(vs), .iData(pix),
    .oWr_en(d_wr), .oWr_addr(d_addr), .oWr_data(d_data), .oBusy(d_busy),
    .oFrame_done(d_done), .oFrame_err(d_err));

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  int   cyc = 0;
  exp_t q_s[$], q_d[$];
  vec_t log_s[$];
  logic img [0:NL-1][0:LINE-1];

  int   wr_s = 0, wr_d = 0, done_s = 0, done_d = 0, err_s = 0, err_d = 0;
  int   exp_done_s = 0, exp_done_d = 0, exp_err_s = 0, exp_err_d = 0;
  bit   m_cap_s = 0, m_cap_d = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon_write(input int id, input int addr, input int data, input int done);
    exp_t e;
    if ((id == 0 && q_s.size() == 0) || (id == 1 && q_d.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_write actual addr=%0d data=%0h required no write (t=%0t)",
               (id == 0) ? "s" : "d", addr, data, $time);
      return;
    end
    if (id == 0) e = q_s.pop_front();
    else         e = q_d.pop_front();
    check((id == 0) ? "s_addr" : "d_addr", addr, e.addr);
    check((id == 0) ? "s_data" : "d_data", data, e.data);
    check((id == 0) ? "s_done_with_write" : "d_done_with_write", done, e.done);
    check((id == 0) ? "s_latency_cycle" : "d_latency_cycle", cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    if (s_wr) begin
      wr_s++;
      log_s.push_back('{int'(s_addr), int'(s_data), int'(s_done)});
      mon_write(0, int'(s_addr), int'(s_data), int'(s_done));
    end
    if (d_wr) begin
      wr_d++;
      mon_write(1, int'(d_addr), int'(d_data), int'(d_done));
      if (int'(d_addr) % 4 == 3)
        check("d_word3_high_bits", int'(d_data[7:6]), 0);
    end
    if (s_done) done_s++;
    if (d_done) done_d++;
    if (s_err)  err_s++;
    if (d_err)  err_d++;
  end

  // Reference model: VS leading edge at (v=0,h=0) of each driven frame.
  task automatic model_vs();
    if (m_cap_s) exp_err_s++;
    if (m_cap_d) exp_err_d++;
    m_cap_s = en_s;
    m_cap_d = en_d;
  endtask

  task automatic model_pix(input int id, input int v, input int h);
    int   r, c, h0, v0, x, y, xx;
    bit   cap;
    exp_t e;
    if (id == 0) begin r = S_ROW; c = S_COL; h0 = S_H; v0 = S_V; cap = m_cap_s; end
    else         begin r = D_ROW; c = D_COL; h0 = D_H; v0 = D_V; cap = m_cap_d; end
    if (!cap) return;
    if (h < h0 || h >= h0 + c || v < v0 || v >= v0 + r) return;
    x = h - h0;
    y = v - v0;
    if (x % 8 != 7 && x != c - 1) return;
    e.addr = y * ((c + 7) / 8) + x / 8;
    e.data = 0;
    for (int k = 0; k < 8; k++) begin
      xx = (x / 8) * 8 + k;
      if (xx < c && img[v][h0 + xx] == 1'b1) e.data = e.data | (1 << k);
    end
    e.done = (y == r - 1 && x == c - 1) ? 1 : 0;
    e.cyc  = cyc + 2;
    if (id == 0) begin
      q_s.push_back(e);
      if (e.done == 1) begin m_cap_s = 0; exp_done_s++; end
    end else begin
      q_d.push_back(e);
      if (e.done == 1) begin m_cap_d = 0; exp_done_d++; end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_wr"},   int'(s_wr),   0);
    check({tag, "_s_addr"}, int'(s_addr), 0);
    check({tag, "_s_data"}, int'(s_data), 0);
    check({tag, "_s_busy"}, int'(s_busy), 0);
    check({tag, "_s_done"}, int'(s_done), 0);
    check({tag, "_s_err"},  int'(s_err),  0);
    check({tag, "_d_wr"},   int'(d_wr),   0);
    check({tag, "_d_busy"}, int'(d_busy), 0);
    check({tag, "_d_data"}, int'(d_data), 0);
  endtask

  // Short asynchronous reset pulse entirely between two rising edges.
  task automatic pulse_reset();
    check("pre_reset_d_busy", int'(d_busy), int'(m_cap_d));
    #1 rst = 1'b1;
    #1 check_outputs_zero("in_reset");
    #1 rst = 1'b0;
    m_cap_s = 0;
    m_cap_d = 0;
  endtask

  task automatic run_frame(input int nlines, input int last_len, input int en_line,
                           input int rst_line);
    int len;
    for (int v = 0; v < nlines; v++) begin
      len = (v == nlines - 1) ? last_len : LINE;
      if (v == en_line) begin en_s = 1'b1; en_d = 1'b1; end
      for (int h = 0; h < len; h++) begin
        @(posedge clk);
        #1;
        hs  = (h < HSW) ? 1'b0 : 1'b1;
        vs  = (v < VSW) ? 1'b0 : 1'b1;
        pix = img[v][h];
        if (v == 0 && h == 0) model_vs();
        model_pix(0, v, h);
        model_pix(1, v, h);
        if (v == rst_line && h == 1) pulse_reset();
      end
    end
  endtask

  task automatic phase_check(input string tag);
    check({tag, "_q_s_empty"}, q_s.size(), 0);
    check({tag, "_q_d_empty"}, q_d.size(), 0);
    check({tag, "_s_busy"}, int'(s_busy), int'(m_cap_s));
    check({tag, "_d_busy"}, int'(d_busy), int'(m_cap_d));
    check({tag, "_s_done_cnt"}, done_s, exp_done_s);
    check({tag, "_d_done_cnt"}, done_d, exp_done_d);
    check({tag, "_s_err_cnt"}, err_s, exp_err_s);
    check({tag, "_d_err_cnt"}, err_d, exp_err_d);
  endtask

  vec_t tbl[8];
  int   base_s, base_d;

  initial begin
    tbl[0] = '{0, 8'hAA, 0};  tbl[1] = '{1, 8'h02, 0};
    tbl[2] = '{2, 8'h55, 0};  tbl[3] = '{3, 8'h01, 0};
    tbl[4] = '{4, 8'hAA, 0};  tbl[5] = '{5, 8'h02, 0};
    tbl[6] = '{6, 8'h55, 0};  tbl[7] = '{7, 8'h01, 1};

    for (int v = 0; v < NL; v++)
      for (int h = 0; h < LINE; h++)
        img[v][h] = 1'((h + v) % 2);

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst = 1'b0;
    run_frame(NL, LINE, -1, -1);
    run_frame(NL, LINE, -1, -1);
    check("idle_s_writes", wr_s, 0);
    check("idle_d_writes", wr_d, 0);
    phase_check("idle");

    // Checkerboard frame on the small window
    en_s = 1'b1;
    log_s.delete();
    run_frame(NL, LINE, -1, -1);
    en_s = 1'b0;
    check("cb_write_count", log_s.size(), 8);
    for (int i = 0; i < 8 && i < log_s.size(); i++) begin
      check($sformatf("cb_addr_%0d", i), log_s[i].addr, tbl[i].addr);
      check($sformatf("cb_data_%0d", i), log_s[i].data, tbl[i].data);
      check($sformatf("cb_done_%0d", i), log_s[i].done, tbl[i].done);
    end
    phase_check("checker");

    // Enable raised mid-frame, then a full frame on both windows
    for (int v = 0; v < NL; v++)
      for (int h = 0; h < LINE; h++)
        img[v][h] = 1'($urandom_range(0, 1));
    base_s = wr_s;
    base_d = wr_d;
    run_frame(NL, LINE, 3, -1);
    check("late_en_s_writes", wr_s - base_s, 0);
    check("late_en_d_writes", wr_d - base_d, 0);
    run_frame(NL, LINE, -1, -1);
    check("full_s_writes", wr_s - base_s, 8);
    check("full_d_writes", wr_d - base_d, 120);
    phase_check("enable");

    // Early VS with a truncated line, then a restarted full frame
    run_frame(4, 9, -1, -1);
    base_s = wr_s;
    base_d = wr_d;
    run_frame(NL, LINE, -1, -1);
    check("restart_s_writes", wr_s - base_s, 8);
    check("restart_d_writes", wr_d - base_d, 120);
    check("abort_s_err", err_s, 1);
    check("abort_d_err", err_d, 1);
    phase_check("early_vs");

    // Async reset during line 10, capture resumes on the next frame
    base_d = done_d;
    run_frame(NL, LINE, -1, 10);
    check("reset_frame_d_no_done", done_d - base_d, 0);
    run_frame(NL, LINE, -1, -1);
    check("post_reset_d_done", done_d - base_d, 1);
    phase_check("mid_reset");

    en_s = 1'b0;
    en_d = 1'b0;
    run_frame(NL, LINE, -1, -1);
    phase_check("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
